// File: rtl/prog_loader_if.sv
// Byte-stream and program-RAM write bundle for the program loader.
// The master end drives the byte stream; the slave end is the loader itself.
interface prog_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: takes a length-prefixed, XOR-checksummed byte stream, writes
// little-endian 16-bit words to program RAM from address 0, holds the CPU until verified.
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DAT_LO = 3'd2,
    S_DAT_HI = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t            state_r;
  logic [15:0]       len_r;
  logic [ADDR_W:0]   wcnt_r;
  logic [7:0]        chk_r;
  logic [7:0]        lo_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [15:0]       mem_data_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              err_r;

  logic              in_ready_s;
  logic              fire_s;
  logic [15:0]       len_full_s;
  logic [15:0]       wcnt_next_s;

  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  function automatic logic len_too_big(input logic [15:0] len);
    return {1'b0, len} > MAX_LEN;
  endfunction

  // Ready depends on state only, never on in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI, S_CHK: in_ready_s = 1'b1;
      default:                                      in_ready_s = 1'b0;
    endcase
  end

  assign fire_s      = in_ready_s & bus.in_valid;
  assign len_full_s  = {bus.in_data, len_r[7:0]};
  assign wcnt_next_s = 16'(wcnt_r) + 16'd1;

  // Loader FSM with registered RAM-port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_LEN_LO;
      len_r      <= 16'd0;
      wcnt_r     <= '0;
      chk_r      <= 8'd0;
      lo_r       <= 8'd0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_data_r <= 16'd0;
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        S_LEN_LO: begin
          if (fire_s) begin
            len_r[7:0] <= bus.in_data;
            state_r    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (fire_s) begin
            len_r[15:8] <= bus.in_data;
            if (len_too_big(len_full_s)) begin
              state_r <= S_ERR;
              err_r   <= 1'b1;
            end else if (len_full_s == 16'd0) begin
              state_r <= S_CHK;
            end else begin
              state_r <= S_DAT_LO;
            end
          end
        end
        S_DAT_LO: begin
          if (fire_s) begin
            lo_r    <= bus.in_data;
            chk_r   <= chk_update(chk_r, bus.in_data);
            state_r <= S_DAT_HI;
          end
        end
        S_DAT_HI: begin
          // Word is latched here so the RAM sees stable addr/data during S_WRITE.
          if (fire_s) begin
            chk_r      <= chk_update(chk_r, bus.in_data);
            mem_data_r <= {bus.in_data, lo_r};
            mem_addr_r <= wcnt_r[ADDR_W-1:0];
            mem_we_r   <= 1'b1;
            state_r    <= S_WRITE;
          end
        end
        S_WRITE: begin
          wcnt_r  <= wcnt_r + {{ADDR_W{1'b0}}, 1'b1};
          state_r <= (wcnt_next_s == len_r) ? S_CHK : S_DAT_LO;
        end
        S_CHK: begin
          if (fire_s) begin
            if (bus.in_data == chk_r) begin
              state_r    <= S_DONE;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              state_r <= S_ERR;
              err_r   <= 1'b1;
            end
          end
        end
        S_DONE: state_r <= S_DONE;
        S_ERR:  state_r <= S_ERR;
        default: begin
          state_r    <= S_ERR;
          err_r      <= 1'b1;
          done_r     <= 1'b0;
          cpu_hold_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.mem_we   = mem_we_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_data = mem_data_r;
  assign bus.cpu_hold = cpu_hold_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader upstream of the instruction memory feeding the computer's PC/fetch path.
- Receives a length-prefixed, checksummed byte stream over a valid/ready handshake.
- Assembles little-endian 16-bit instruction words and writes them to sequential program RAM addresses from 0.
- Holds the CPU in reset until the load completes and verifies.

Parameters:
- ADDR_W, 8, program RAM address width.
- MAX_WORDS, 256, largest accepted word count; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  8  incoming stream byte
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  program RAM write strobe, one cycle per word
- mem_addr  output  ADDR_W  program RAM write address
- mem_data  output  16  program RAM write data
- cpu_hold  output  1  high holds the computer (PC and control) in reset
- done  output  1  load complete and checksum matched; sticky
- err  output  1  load failed (length or checksum); sticky

Behaviour:
- Byte transfer: occurs on a rising edge with in_valid && in_ready. in_ready is combinational from state only and never depends on in_valid.
- Stream format: LEN_LO, LEN_HI, then N words sent as LO, HI byte pairs, then one CHK byte.
- CHK = XOR of all data bytes. Length bytes are excluded from the checksum.
- Reset: state=S_LEN_LO; in_ready=1; mem_we=0; mem_addr=0; mem_data=0; cpu_hold=1; done=0; err=0; word count, length and checksum registers cleared. RAM contents are not cleared.
- States and transitions:
  - S_LEN_LO: accept byte → len[7:0]; go to S_LEN_HI.
  - S_LEN_HI: accept byte → len[15:8].
    - If full 16-bit len > MAX_WORDS → S_ERR.
    - Else if len==0 → S_CHK.
    - Else → S_DAT_LO.
  - S_DAT_LO: accept byte → lo register; chk ^= byte; go to S_DAT_HI.
  - S_DAT_HI: accept byte; chk ^= byte; go to S_WRITE. On that same edge, register mem_data={byte,lo} and mem_addr=wcnt.
  - S_WRITE: mem_we=1 for exactly this one cycle; in_ready=0; wcnt increments. Next state is S_CHK if wcnt+1==len, else S_DAT_LO.
  - S_CHK: accept byte. If byte==chk → S_DONE, else → S_ERR.
  - S_DONE: done=1, cpu_hold=0, in_ready=0. Terminal until rst.
  - S_ERR: err=1, cpu_hold=1, in_ready=0. Terminal until rst.
- in_ready=1 only in S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI and S_CHK.
- Throughput: 3 cycles per word minimum (LO, HI, WRITE).
- Stalls: in_valid low simply holds state; there is no timeout.
- mem_addr/mem_data: hold their last value outside S_WRITE. mem_we is 0 in every state except S_WRITE.
- done and err are mutually exclusive and never both high.
- Word counter: width ADDR_W+1 so that len==MAX_WORDS is reachable without wrap. The highest address written is len-1.
- Reset mid-load: returns to S_LEN_LO next cycle, mem_we drops immediately, cpu_hold=1. The next byte is treated as LEN_LO.
- Reset in S_DONE: cpu_hold reasserts and done clears; the program must be reloaded.
- Bytes presented while in_ready=0 are not consumed, and the source must hold them.

Test Plan:
- Nominal load: stream 04 00 D0 8F D0 87 01 00 07 80 8E → four mem_we pulses writing addr0=0x8FD0, addr1=0x87D0, addr2=0x0001, addr3=0x8007. Then done=1, cpu_hold=0, err=0.
- Bad checksum: same stream with final byte 8F → four writes, then err=1, cpu_hold stays 1, done=0, in_ready=0.
- Zero length: stream 00 00 00 → no mem_we; done=1 after the CHK byte. The same header with CHK 01 → err=1.
- Oversize: len bytes 01 01 (257) with MAX_WORDS=256 → err=1 immediately after LEN_HI, zero writes. Len 00 01 (256) is accepted, with the last write at addr 0xFF.
- Backpressure/gaps: insert random in_valid=0 cycles and hold in_valid=1 across S_WRITE cycles → data and addresses identical to the nominal case; in_ready=0 in every S_WRITE cycle; no byte lost or duplicated.
- Reset mid-operation: assert rst for one cycle after the 5th byte of the nominal stream → mem_we=0 and cpu_hold=1 next cycle. Then resend the full nominal stream → correct four writes and done=1.
